// File: rtl/adc_avg_capture.sv
// Multi-channel ADC capture: retiming pipeline with enable gating, then
// per-channel block averaging of 2^AVG_LOG2 samples and sticky full-scale flags.
module adc_avg_capture #(
  parameter int DATA_W      = 12,
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] adc_data_in,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic                     out_valid,
  output logic [NUM_CH-1:0]        ovr
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [SYNC_STAGES-1:0]   pipe_vld_q, pipe_vld_d;
  logic [NUM_CH*DATA_W-1:0] pipe_data_q [SYNC_STAGES];
  logic [NUM_CH*DATA_W-1:0] pipe_data_d [SYNC_STAGES];

  logic [ACC_W-1:0]         acc_q [NUM_CH];
  logic [ACC_W-1:0]         acc_d [NUM_CH];
  logic [ACC_W-1:0]         sum   [NUM_CH];
  logic [DATA_W-1:0]        samp  [NUM_CH];
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [NUM_CH*DATA_W-1:0] data_out_q, data_out_d;
  logic                     out_valid_q, out_valid_d;
  logic [NUM_CH-1:0]        ovr_q, ovr_d;

  logic                     take;
  logic                     blk_done;

  always_comb begin
    pipe_vld_d = pipe_vld_q;
    for (int s = 0; s < SYNC_STAGES; s++) begin
      pipe_data_d[s] = pipe_data_q[s];
    end
    // Clear kills only the valid bits; stale data behind them is harmless.
    if (clr) begin
      pipe_vld_d = '0;
    end else if (en) begin
      pipe_vld_d[0]  = in_valid;
      pipe_data_d[0] = adc_data_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        pipe_vld_d[s]  = pipe_vld_q[s-1];
        pipe_data_d[s] = pipe_data_q[s-1];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      samp[c] = pipe_data_q[SYNC_STAGES-1][c*DATA_W +: DATA_W];
      sum[c]  = acc_q[c] + ACC_W'(samp[c]);
    end
  end

  assign take     = en && !clr && pipe_vld_q[SYNC_STAGES-1];
  assign blk_done = take && (cnt_q == BLK_LAST);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      acc_d[c] = acc_q[c];
    end
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    ovr_d       = ovr_q;
    if (clr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_d[c] = '0;
      end
      cnt_d = '0;
      ovr_d = '0;
    end else if (take) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (samp[c] == {DATA_W{1'b1}}) begin
          ovr_d[c] = 1'b1;
        end
      end
      // The final sample is folded in combinationally so the block closes on it.
      if (blk_done) begin
        for (int c = 0; c < NUM_CH; c++) begin
          acc_d[c] = '0;
          data_out_d[c*DATA_W +: DATA_W] = DATA_W'(sum[c] >> AVG_LOG2);
        end
        cnt_d       = '0;
        out_valid_d = 1'b1;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          acc_d[c] = sum[c];
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_vld_q <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        pipe_data_q[s] <= '0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
      end
      cnt_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      ovr_q       <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        pipe_data_q[s] <= pipe_data_d[s];
      end
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
      end
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_adc_avg_capture.sv
// Directed bench for adc_avg_capture: a default averaging instance and a
// bypass (AVG_LOG2=0) instance share one stimulus stream.
module tb_adc_avg_capture;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        clr;
  logic        in_valid;
  logic [23:0] adc_data_in;

  logic [23:0] data_out_avg;
  logic        out_valid_avg;
  logic [1:0]  ovr_avg;
  logic [23:0] data_out_byp;
  logic        out_valid_byp;
  logic [1:0]  ovr_byp;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  adc_avg_capture #(.DATA_W(12), .NUM_CH(2), .SYNC_STAGES(2), .AVG_LOG2(2)) dut_avg (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .in_valid(in_valid),
    .adc_data_in(adc_data_in), .data_out(data_out_avg),
    .out_valid(out_valid_avg), .ovr(ovr_avg)
  );

  adc_avg_capture #(.DATA_W(12), .NUM_CH(2), .SYNC_STAGES(2), .AVG_LOG2(0)) dut_byp (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .in_valid(in_valid),
    .adc_data_in(adc_data_in), .data_out(data_out_byp),
    .out_valid(out_valid_byp), .ovr(ovr_byp)
  );

  // Drive one sample set, then step past the next rising edge.
  task automatic applyStimulus(input logic v, input logic [11:0] c0, input logic [11:0] c1);
    in_valid    = v;
    adc_data_in = {c1, c0};
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; clr = 1'b0; in_valid = 1'b0; adc_data_in = '0;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("reset_data", 32'(data_out_avg), 0);
    checkOutput("reset_valid", 32'(out_valid_avg), 0);
    checkOutput("reset_ovr", 32'(ovr_avg), 0);
    rstn = 1'b1;
    repeat (3) applyStimulus(0, 0, 0);
    checkOutput("idle_data", 32'(data_out_avg), 0);
    checkOutput("idle_valid", 32'(out_valid_avg), 0);

    // Basic average with full-scale channel 1
    applyStimulus(1, 100, 4095);
    applyStimulus(1, 200, 4095);
    applyStimulus(1, 300, 4095);
    applyStimulus(1, 400, 4095);
    applyStimulus(0, 0, 0);
    checkOutput("avg_early", 32'(out_valid_avg), 0);
    applyStimulus(0, 0, 0);
    checkOutput("avg_valid", 32'(out_valid_avg), 1);
    checkOutput("avg_ch0", 32'(data_out_avg[11:0]), 250);
    checkOutput("avg_ch1", 32'(data_out_avg[23:12]), 4095);
    checkOutput("avg_ovr", 32'(ovr_avg), 2);
    applyStimulus(0, 0, 0);
    checkOutput("avg_pulse_end", 32'(out_valid_avg), 0);
    checkOutput("avg_hold", 32'(data_out_avg[11:0]), 250);

    // Floor truncation: 5 >> 2 = 1
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 2, 0);
    applyStimulus(0, 0, 0);
    checkOutput("trunc_early", 32'(out_valid_avg), 0);
    applyStimulus(0, 0, 0);
    checkOutput("trunc_valid", 32'(out_valid_avg), 1);
    checkOutput("trunc_ch0", 32'(data_out_avg[11:0]), 1);
    checkOutput("trunc_ch1", 32'(data_out_avg[23:12]), 0);
    checkOutput("trunc_ovr_sticky", 32'(ovr_avg), 2);
    applyStimulus(0, 0, 0);

    // Enable stall of 5 cycles after the second sample; in_valid held high
    // with junk while stalled must be ignored.
    applyStimulus(1, 100, 0);
    applyStimulus(1, 200, 0);
    en = 1'b0;
    repeat (5) begin
      applyStimulus(1, 999, 7);
      checkOutput("stall_no_valid", 32'(out_valid_avg), 0);
    end
    en = 1'b1;
    applyStimulus(1, 300, 0);
    applyStimulus(1, 400, 0);
    applyStimulus(0, 0, 0);
    checkOutput("stall_early", 32'(out_valid_avg), 0);
    applyStimulus(0, 0, 0);
    checkOutput("stall_valid", 32'(out_valid_avg), 1);
    checkOutput("stall_ch0", 32'(data_out_avg[11:0]), 250);
    applyStimulus(0, 0, 0);
    checkOutput("stall_single", 32'(out_valid_avg), 0);

    // Clear discards a partial block and ovr; data_out holds
    applyStimulus(1, 1000, 4095);
    applyStimulus(1, 1000, 4095);
    clr = 1'b1;
    applyStimulus(0, 0, 0);
    clr = 1'b0;
    checkOutput("clr_ovr", 32'(ovr_avg), 0);
    checkOutput("clr_hold", 32'(data_out_avg[11:0]), 250);
    checkOutput("clr_valid", 32'(out_valid_avg), 0);
    applyStimulus(1, 8, 8);
    applyStimulus(1, 8, 8);
    applyStimulus(1, 8, 8);
    checkOutput("clr_no_early", 32'(out_valid_avg), 0);
    applyStimulus(1, 8, 8);
    applyStimulus(0, 0, 0);
    checkOutput("clr_early", 32'(out_valid_avg), 0);
    applyStimulus(0, 0, 0);
    checkOutput("clr_block_valid", 32'(out_valid_avg), 1);
    checkOutput("clr_block_ch0", 32'(data_out_avg[11:0]), 8);
    checkOutput("clr_block_ch1", 32'(data_out_avg[23:12]), 8);
    checkOutput("clr_block_ovr", 32'(ovr_avg), 0);
    applyStimulus(0, 0, 0);

    // Async reset mid-block, away from any clock edge
    applyStimulus(1, 5, 4095);
    applyStimulus(1, 5, 4095);
    applyStimulus(1, 5, 4095);
    checkOutput("pre_rst_ovr", 32'(ovr_avg), 2);
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_data", 32'(data_out_avg), 0);
    checkOutput("async_rst_valid", 32'(out_valid_avg), 0);
    checkOutput("async_rst_ovr", 32'(ovr_avg), 0);
    checkOutput("async_rst_byp_data", 32'(data_out_byp), 0);
    applyStimulus(0, 0, 0);
    rstn = 1'b1;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("post_rst_valid", 32'(out_valid_avg), 0);
    applyStimulus(1, 20, 40);
    applyStimulus(1, 20, 40);
    applyStimulus(1, 20, 40);
    applyStimulus(1, 20, 40);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("fresh_valid", 32'(out_valid_avg), 1);
    checkOutput("fresh_ch0", 32'(data_out_avg[11:0]), 20);
    checkOutput("fresh_ch1", 32'(data_out_avg[23:12]), 40);
    applyStimulus(0, 0, 0);

    // Bypass instance: 7, gap, 9
    applyStimulus(1, 7, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("byp_valid1", 32'(out_valid_byp), 1);
    checkOutput("byp_data1", 32'(data_out_byp[11:0]), 7);
    checkOutput("byp_data1_ch1", 32'(data_out_byp[23:12]), 0);
    applyStimulus(1, 9, 0);
    checkOutput("byp_gap_valid", 32'(out_valid_byp), 0);
    checkOutput("byp_gap_hold", 32'(data_out_byp[11:0]), 7);
    applyStimulus(0, 0, 0);
    checkOutput("byp_gap_valid2", 32'(out_valid_byp), 0);
    applyStimulus(0, 0, 0);
    checkOutput("byp_valid2", 32'(out_valid_byp), 1);
    checkOutput("byp_data2", 32'(data_out_byp[11:0]), 9);
    checkOutput("avg_partial_quiet", 32'(out_valid_avg), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
